// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding word read at a time, results queued
// in a small {pc, instruction} prefetch FIFO drained by decode; redirects flush it.
module fetch_unit #(
    parameter int  MEM_DEPTH  = 8,
    parameter int  DATA_WIDTH = 32,
    parameter int  BUF_DEPTH  = 4,
    parameter int  RESET_PC   = 0,
    localparam int ADDR_WIDTH = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1,
    localparam int CNT_WIDTH  = $clog2(BUF_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_req_valid,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_rdata_valid,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  instr_valid,
    output logic [DATA_WIDTH-1:0] instr_data,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    input  logic                  instr_ready,
    output logic [CNT_WIDTH-1:0]  buf_count
);

    localparam int PTR_WIDTH = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

    typedef enum logic {S_REQ, S_WAIT} state_t;

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  drop;
    logic [PTR_WIDTH-1:0]  rd_ptr, wr_ptr;
    logic [CNT_WIDTH-1:0]  count;
    logic [ADDR_WIDTH-1:0] buf_pc   [BUF_DEPTH];
    logic [DATA_WIDTH-1:0] buf_data [BUF_DEPTH];

    logic issue, push, pop;

    function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
        return (p == PTR_WIDTH'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] pc_inc(input logic [ADDR_WIDTH-1:0] p);
        return (p == ADDR_WIDTH'(MEM_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Redirect overrides issue, push and pop in the same cycle.
    always_comb begin
        issue = (state == S_REQ) && !redirect_valid && (count < CNT_WIDTH'(BUF_DEPTH));
        push  = (state == S_WAIT) && mem_rdata_valid && !drop && !redirect_valid;
        pop   = (count != '0) && instr_ready && !redirect_valid;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_REQ;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            S_REQ:   if (issue) state_next = S_WAIT;
            S_WAIT:  if (mem_rdata_valid) state_next = S_REQ;
            default: state_next = S_REQ;
        endcase
    end

    always_comb begin
        mem_req_valid = (state == S_WAIT);
        mem_we        = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc       <= ADDR_WIDTH'(RESET_PC);
            mem_addr <= '0;
            drop     <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (issue) mem_addr <= pc;
            if (redirect_valid) begin
                pc     <= redirect_pc;
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
                // A response landing with the redirect is discarded now; otherwise squash it later.
                if (state == S_WAIT) drop <= !mem_rdata_valid;
            end else begin
                if (push) begin
                    wr_ptr <= ptr_inc(wr_ptr);
                    pc     <= pc_inc(pc);
                end
                if (pop) rd_ptr <= ptr_inc(rd_ptr);
                if (push && !pop)      count <= count + 1'b1;
                else if (pop && !push) count <= count - 1'b1;
                if ((state == S_WAIT) && mem_rdata_valid) drop <= 1'b0;
            end
        end
    end

    // NOTE: FIFO storage is not reset; count alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_pc[wr_ptr]   <= pc;
            buf_data[wr_ptr] <= mem_rdata;
        end
    end

    always_comb begin
        instr_valid = (count != '0);
        instr_data  = buf_data[rd_ptr];
        instr_pc    = buf_pc[rd_ptr];
        buf_count   = count;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a behavioural memory with programmable latency feeds a
// scoreboard of expected {pc, data} pairs that a monitor checks on each handshake.
`timescale 1ns/1ps
module tb_fetch_unit;

    localparam int MEM_DEPTH = 8;
    localparam int BUF_DEPTH = 4;
    localparam int AW = 3;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] mem_addr;
    logic          mem_req_valid, mem_we;
    logic [31:0]   mem_rdata = '0;
    logic          mem_rdata_valid = 1'b0;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic          instr_valid;
    logic [31:0]   instr_data;
    logic [AW-1:0] instr_pc;
    logic          instr_ready = 1'b0;
    logic [CW-1:0] buf_count;

    logic [AW-1:0] d3_addr, d3_ipc;
    logic          d3_req, d3_we, d3_iv;
    logic [31:0]   d3_idata;
    logic [CW-1:0] d3_cnt;

    fetch_unit #(.MEM_DEPTH(MEM_DEPTH), .DATA_WIDTH(32), .BUF_DEPTH(BUF_DEPTH), .RESET_PC(0)) dut (
        .clk(clk), .reset(reset),
        .mem_addr(mem_addr), .mem_req_valid(mem_req_valid), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .mem_rdata_valid(mem_rdata_valid),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_data(instr_data), .instr_pc(instr_pc),
        .instr_ready(instr_ready), .buf_count(buf_count)
    );

    // Second instance only exercises a non-zero reset PC; it never gets a response.
    fetch_unit #(.MEM_DEPTH(MEM_DEPTH), .DATA_WIDTH(32), .BUF_DEPTH(BUF_DEPTH), .RESET_PC(3)) dut3 (
        .clk(clk), .reset(reset),
        .mem_addr(d3_addr), .mem_req_valid(d3_req), .mem_we(d3_we),
        .mem_rdata(32'h0), .mem_rdata_valid(1'b0),
        .redirect_valid(1'b0), .redirect_pc(3'd0),
        .instr_valid(d3_iv), .instr_data(d3_idata), .instr_pc(d3_ipc),
        .instr_ready(1'b0), .buf_count(d3_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          pc;
        logic [31:0] data;
    } entry_t;

    entry_t exp_q[$];
    entry_t pop_log[$];
    int     req_log[$];
    int     n_cmp = 0;
    int     n_fail = 0;
    int     exp_pc = 0;
    int     lat = 1;
    int     wait_cnt = 0;
    bit     pending = 1'b0;
    bit     stale = 1'b0;
    bit     rand_lat = 1'b0;
    logic          prev_v = 1'b0;
    logic [AW-1:0] prev_a = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pattern(input int a);
        return 32'hA000_0000 + 32'(a);
    endfunction

    function automatic int next_pc(input int p);
        return (p == MEM_DEPTH - 1) ? 0 : p + 1;
    endfunction

    always @(posedge clk)
        if (!reset && redirect_valid)
            assert (int'(redirect_pc) < MEM_DEPTH) else $error("redirect_pc out of range");

    // Memory: latency L means the response is sampled on the (L+1)th edge after the request appears.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (reset) begin
                mem_rdata_valid = 1'b0;
                pending = 1'b0;
            end else if (mem_rdata_valid) begin
                mem_rdata_valid = 1'b0;
                pending = 1'b0;
            end else if (mem_req_valid) begin
                if (!pending) begin
                    pending = 1'b1;
                    wait_cnt = rand_lat ? int'($urandom_range(1, 5)) : lat;
                    req_log.push_back(int'(mem_addr));
                    check("req_addr", 64'(mem_addr), 64'(exp_pc));
                end else begin
                    wait_cnt--;
                    if (wait_cnt == 0) begin
                        mem_rdata = pattern(int'(mem_addr));
                        mem_rdata_valid = 1'b1;
                        if (stale) begin
                            stale = 1'b0;
                        end else begin
                            exp_q.push_back('{exp_pc, pattern(exp_pc)});
                            exp_pc = next_pc(exp_pc);
                        end
                    end
                end
            end
        end
    end

    // Monitor: samples on the falling edge, pops the scoreboard on each accepted handshake.
    initial begin
        entry_t e;
        forever begin
            @(negedge clk);
            check("mem_we", 64'(mem_we), 64'd0);
            if (reset) begin
                prev_v = 1'b0;
            end else begin
                if (mem_req_valid && prev_v) check("addr_stable", 64'(mem_addr), 64'(prev_a));
                prev_v = mem_req_valid;
                prev_a = mem_addr;
                if (instr_valid && instr_ready && !redirect_valid) begin
                    check("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("instr_pc", 64'(instr_pc), 64'(e.pc));
                        check("instr_data", 64'(instr_data), 64'(e.data));
                        pop_log.push_back('{int'(instr_pc), instr_data});
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk); #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        redirect_valid = 1'b0;
        instr_ready = 1'b0;
        rand_lat = 1'b0;
        lat = 1;
        exp_q.delete();
        pop_log.delete();
        req_log.delete();
        stale = 1'b0;
        exp_pc = 0;
        repeat (2) step();
        reset = 1'b0;
    endtask

    task automatic set_redirect(input int pc);
        redirect_valid = 1'b1;
        redirect_pc = pc[AW-1:0];
        if (pending && !mem_rdata_valid) stale = 1'b1;
        exp_q.delete();
        exp_pc = pc;
    endtask

    task automatic wait_req(input int n, input string name);
        int k = 0;
        while (req_log.size() < n && k < 200) begin
            step();
            k++;
        end
        check({name, "_req_timeout"}, 64'(req_log.size() >= n), 64'd1);
    endtask

    task automatic wait_pop(input int n, input string name);
        int k = 0;
        while (pop_log.size() < n && k < 200) begin
            step();
            k++;
        end
        check({name, "_pop_timeout"}, 64'(pop_log.size() >= n), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int n_redir;

        // Reset values, first-request latency, linear fetch with wrap.
        step(); step();
        check("rst_req_valid", 64'(mem_req_valid), 64'd0);
        check("rst_instr_valid", 64'(instr_valid), 64'd0);
        check("rst_buf_count", 64'(buf_count), 64'd0);
        check("rst_d3_req", 64'(d3_req), 64'd0);
        check("rst_d3_count", 64'(d3_cnt), 64'd0);
        reset = 1'b0;
        instr_ready = 1'b1;
        @(negedge clk);
        check("req_before_edge", 64'(mem_req_valid), 64'd0);
        step();
        check("req_after_edge", 64'(mem_req_valid), 64'd1);
        check("first_addr", 64'(mem_addr), 64'd0);
        check("d3_first_req", 64'(d3_req), 64'd1);
        check("d3_first_addr", 64'(d3_addr), 64'd3);
        check("d3_we", 64'(d3_we), 64'd0);
        check("d3_idle_fifo", 64'(d3_iv), 64'd0);
        wait_req(9, "t1");
        for (int i = 0; i < 9 && i < req_log.size(); i++)
            check("wrap_seq", 64'(req_log[i]), 64'(i % MEM_DEPTH));

        // Full stall with decode blocked, then one pop frees a slot.
        do_reset();
        repeat (30) step();
        check("stall_reqs", 64'(req_log.size()), 64'd4);
        for (int i = 0; i < 4 && i < req_log.size(); i++)
            check("stall_addr", 64'(req_log[i]), 64'(i));
        check("stall_count", 64'(buf_count), 64'd4);
        check("stall_no_req", 64'(mem_req_valid), 64'd0);
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        check("one_pop", 64'(pop_log.size()), 64'd1);
        wait_req(5, "t2");
        if (req_log.size() >= 5) check("after_pop_addr", 64'(req_log[4]), 64'd4);

        // Redirect while waiting on addr 2; its late response must be squashed.
        do_reset();
        instr_ready = 1'b1;
        wait_req(2, "t3a");
        lat = 3;
        wait_req(3, "t3b");
        lat = 1;
        if (req_log.size() >= 3) check("t3_pending_addr", 64'(req_log[2]), 64'd2);
        set_redirect(5);
        step();
        redirect_valid = 1'b0;
        check("t3_req_held", 64'(mem_req_valid), 64'd1);
        check("t3_addr_held", 64'(mem_addr), 64'd2);
        pop_log.delete();
        wait_req(4, "t3c");
        if (req_log.size() >= 4) check("t3_redirect_addr", 64'(req_log[3]), 64'd5);
        wait_pop(1, "t3");
        if (pop_log.size() >= 1) begin
            check("t3_first_pc", 64'(pop_log[0].pc), 64'd5);
            check("t3_first_data", 64'(pop_log[0].data), 64'(pattern(5)));
        end

        // Redirect coincident with a response and a pop, two entries buffered.
        do_reset();
        wait_req(3, "t4a");
        check("t4_count", 64'(buf_count), 64'd2);
        k = 0;
        while (!mem_rdata_valid && k < 20) begin
            step();
            k++;
        end
        check("t4_resp_seen", 64'(mem_rdata_valid), 64'd1);
        set_redirect(6);
        instr_ready = 1'b1;
        step();
        redirect_valid = 1'b0;
        instr_ready = 1'b0;
        check("t4_count0", 64'(buf_count), 64'd0);
        check("t4_valid0", 64'(instr_valid), 64'd0);
        wait_req(4, "t4b");
        if (req_log.size() >= 4) check("t4_addr", 64'(req_log[3]), 64'd6);
        check("t4_no_pops", 64'(pop_log.size()), 64'd0);

        // Asynchronous reset in WAIT with three entries buffered.
        do_reset();
        lat = 3;
        wait_req(4, "t5a");
        step();
        check("t5_count", 64'(buf_count), 64'd3);
        check("t5_in_wait", 64'(mem_req_valid), 64'd1);
        reset = 1'b1;
        #1;
        check("t5_async_req", 64'(mem_req_valid), 64'd0);
        check("t5_async_count", 64'(buf_count), 64'd0);
        check("t5_async_valid", 64'(instr_valid), 64'd0);
        check("t5_async_d3_req", 64'(d3_req), 64'd0);
        do_reset();
        wait_req(1, "t5b");
        if (req_log.size() >= 1) check("t5_first_addr", 64'(req_log[0]), 64'd0);
        check("t5_d3_addr", 64'(d3_addr), 64'd3);
        check("t5_d3_req", 64'(d3_req), 64'd1);

        // Random latency, back-pressure and redirects against the scoreboard.
        do_reset();
        rand_lat = 1'b1;
        n_redir = 0;
        for (int c = 0; c < 1500; c++) begin
            instr_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 11) == 0) begin
                set_redirect(int'($urandom_range(0, MEM_DEPTH - 1)));
                n_redir++;
            end else begin
                redirect_valid = 1'b0;
            end
            step();
        end
        redirect_valid = 1'b0;
        instr_ready = 1'b1;
        repeat (30) step();
        check("t6_progress", 64'(pop_log.size() > 50), 64'd1);
        check("t6_redirects", 64'(n_redir > 0), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Parametrised instruction fetch unit: the next generation of the core's single-request fetch FSM. Issues word-addressed instruction reads to instruction memory, one outstanding request at a time. Fills a BUF_DEPTH-entry prefetch FIFO of {pc, instruction} pairs, which decode drains through a valid/ready handshake. Adds a redirect (branch/jump) port that flushes the buffer and squashes an in-flight response; PC wraps at MEM_DEPTH.

Parameters:
MEM_DEPTH, 8, instruction memory depth in words; ADDR_WIDTH = $clog2(MEM_DEPTH) is a derived localparam.
DATA_WIDTH, 32, instruction word width.
BUF_DEPTH, 4, prefetch FIFO entries (>=1; need not be a power of two).
RESET_PC, 0, PC value loaded at reset (< MEM_DEPTH).

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
mem_addr  output  ADDR_WIDTH  request word address, held stable while mem_req_valid=1
mem_req_valid  output  1  read request outstanding
mem_we  output  1  write enable, constant 0 (read-only port)
mem_rdata  input  DATA_WIDTH  read data, sampled when mem_rdata_valid=1
mem_rdata_valid  input  1  one-cycle pulse completing the outstanding request
redirect_valid  input  1  one-cycle redirect pulse
redirect_pc  input  ADDR_WIDTH  new fetch address, must be < MEM_DEPTH
instr_valid  output  1  FIFO head valid
instr_data  output  DATA_WIDTH  FIFO head instruction
instr_pc  output  ADDR_WIDTH  FIFO head address
instr_ready  input  1  decode accepts head when instr_valid & instr_ready
buf_count  output  $clog2(BUF_DEPTH+1)  current FIFO occupancy

Behaviour:
- Reset (async, any state, including mid-request): state=REQ, pc=RESET_PC, mem_addr=0, count=0, rd/wr pointers=0, drop=0. Outputs: mem_req_valid=0, instr_valid=0, buf_count=0, mem_we=0. instr_data and instr_pc are don't-care while instr_valid=0.
- FSM states:
  - REQ: mem_req_valid=0. If redirect_valid, apply the redirect and stay in REQ. Else if count<BUF_DEPTH, latch mem_addr<=pc and go to WAIT. Else stay in REQ (full stall).
  - WAIT: mem_req_valid=1, mem_addr unchanged.
    - mem_rdata_valid & !drop & !redirect_valid: push {pc, mem_rdata}; pc<=pc+1, wrapping MEM_DEPTH-1 -> 0; go to REQ.
    - mem_rdata_valid & (drop | redirect_valid): discard the data, clear drop, go to REQ.
    - redirect_valid & !mem_rdata_valid: set drop=1 and stay in WAIT. The memory request is never withdrawn.
- Redirect, any state: pc<=redirect_pc, FIFO flushed (count=0, pointers=0), so instr_valid=0 the next cycle. Redirect takes priority over a same-cycle push and pop. A second redirect while drop=1 only updates pc.
- Space check at issue is sufficient: there is a single writer and one outstanding request, so a response never finds the FIFO full.
- FIFO:
  - Head is read combinationally from storage; instr_valid = (count != 0).
  - Pop when instr_valid & instr_ready.
  - Simultaneous push and pop leaves count unchanged. Pointers wrap at BUF_DEPTH.
  - Popping when empty has no effect.
- Latency:
  - mem_req_valid rises after the 1st rising edge following reset deassertion.
  - A response at edge N raises instr_valid after edge N (visible in cycle N+1).
  - Steady state is one fetch per (2 + memory latency) cycles.
- A redirect_pc >= MEM_DEPTH is out of contract; the bench flags it with an assertion.

Test Plan:
- Reset, 1-cycle memory, instr_ready=1, MEM_DEPTH=8 -> mem_addr sequence 0,1,...,7,0 (wrap). Pairs (pc, data) delivered in order, with data = pattern 0xA000_0000+addr.
- instr_ready=0, BUF_DEPTH=4 -> exactly 4 requests issued (addrs 0-3), buf_count=4, mem_req_valid stays 0. Then instr_ready=1 for 1 cycle -> pc 0 popped, next request addr 4.
- Redirect to 5 during WAIT for addr 2, response 3 cycles later -> addr-2 data never appears, drop cleared, next request addr 5, first delivered instr_pc=5.
- Redirect to 6 coincident with mem_rdata_valid and an instr_ready pop, buffer holding 2 entries -> next cycle buf_count=0, instr_valid=0, response discarded, next request addr 6.
- Reset asserted while in WAIT with 3 entries buffered -> immediately mem_req_valid=0, buf_count=0. After release, first request addr=RESET_PC (rerun with RESET_PC=3 -> first mem_addr=3).
- Random memory latency 1-5 cycles, random instr_ready and redirects -> scoreboard sees in-order pc/data with no post-redirect stale entries, mem_addr stable while mem_req_valid=1, and mem_we always 0.
